// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: decodes debounced key presses, rejects reversals and queues turns.
// Build option SNAKE_DIR_QUEUE_EN: 2-entry turn FIFO; otherwise a single "latest wins" pending turn.
module snake_dir_ctrl #(
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    input  logic [3:0] key_value,
    input  logic       move_tick,
    input  logic       game_restart,
    output logic [1:0] cur_dir,
    output logic       dir_changed,
    output logic [1:0] q_count,
    output logic       key_reject
);

    localparam int unsigned DIR_W = 2;
    localparam int unsigned CNT_W = 2;

    logic [DIR_W-1:0] cur_dir_q, cur_dir_d;
    logic             dir_changed_q, dir_changed_d;
    logic [CNT_W-1:0] q_count_q, q_count_d;
    logic             key_reject_q, key_reject_d;

    logic             key_valid_c;
    logic [DIR_W-1:0] key_dir_c;
    logic [DIR_W-1:0] ref_dir_c;
    logic             pop_c;
    logic             key_ok_c;
    logic             key_rev_c;
    logic [CNT_W-1:0] cnt_c;

`ifdef SNAKE_DIR_QUEUE_EN
    logic [DIR_W-1:0] q0_q, q0_d;
    logic [DIR_W-1:0] q1_q, q1_d;
`else
    logic [DIR_W-1:0] pend_q, pend_d;
`endif

    // Only a single pressed (low) key decodes to a direction.
    always_comb begin
        key_valid_c = 1'b1;
        key_dir_c   = '0;
        case (key_value)
            4'b1110: key_dir_c = DIR_W'(0);
            4'b1101: key_dir_c = DIR_W'(1);
            4'b1011: key_dir_c = DIR_W'(2);
            4'b0111: key_dir_c = DIR_W'(3);
            default: key_valid_c = 1'b0;
        endcase
    end

    // Next-state: restart wins, then pop-on-tick, then push of a legal key.
    always_comb begin
        cur_dir_d     = cur_dir_q;
        dir_changed_d = 1'b0;
        q_count_d     = q_count_q;
        key_reject_d  = 1'b0;
        cnt_c         = q_count_q;
`ifdef SNAKE_DIR_QUEUE_EN
        q0_d      = q0_q;
        q1_d      = q1_q;
        ref_dir_c = (q_count_q == CNT_W'(0)) ? cur_dir_q :
                    (q_count_q == CNT_W'(1)) ? q0_q : q1_q;
`else
        pend_d    = pend_q;
        ref_dir_c = cur_dir_q;
`endif
        pop_c     = move_tick && (q_count_q != CNT_W'(0));
        key_rev_c = key_flag && key_valid_c && ((key_dir_c ^ ref_dir_c) == 2'b01);
        key_ok_c  = key_flag && key_valid_c && (key_dir_c != ref_dir_c) && !key_rev_c;

        if (game_restart) begin
            cur_dir_d = INIT_DIR;
            q_count_d = '0;
`ifdef SNAKE_DIR_QUEUE_EN
            q0_d = '0;
            q1_d = '0;
`else
            pend_d = '0;
`endif
        end else begin
            key_reject_d = key_rev_c;
`ifdef SNAKE_DIR_QUEUE_EN
            if (pop_c) begin
                cur_dir_d     = q0_q;
                dir_changed_d = 1'b1;
                q0_d          = q1_q;
                q1_d          = '0;
                cnt_c         = CNT_W'(q_count_q - CNT_W'(1));
            end
            if (key_ok_c) begin
                if (cnt_c == CNT_W'(2)) begin
                    key_reject_d = 1'b1;
                end else begin
                    if (cnt_c == CNT_W'(0)) q0_d = key_dir_c;
                    else                    q1_d = key_dir_c;
                    cnt_c = CNT_W'(cnt_c + CNT_W'(1));
                end
            end
`else
            if (pop_c) begin
                cur_dir_d     = pend_q;
                dir_changed_d = 1'b1;
                cnt_c         = '0;
            end
            // A newer legal key simply replaces whatever is pending.
            if (key_ok_c) begin
                pend_d = key_dir_c;
                cnt_c  = CNT_W'(1);
            end
`endif
            q_count_d = cnt_c;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_dir_q     <= INIT_DIR;
            dir_changed_q <= 1'b0;
            q_count_q     <= '0;
            key_reject_q  <= 1'b0;
`ifdef SNAKE_DIR_QUEUE_EN
            q0_q <= '0;
            q1_q <= '0;
`else
            pend_q <= '0;
`endif
        end else begin
            cur_dir_q     <= cur_dir_d;
            dir_changed_q <= dir_changed_d;
            q_count_q     <= q_count_d;
            key_reject_q  <= key_reject_d;
`ifdef SNAKE_DIR_QUEUE_EN
            q0_q <= q0_d;
            q1_q <= q1_d;
`else
            pend_q <= pend_d;
`endif
        end
    end

    assign cur_dir     = cur_dir_q;
    assign dir_changed = dir_changed_q;
    assign q_count     = q_count_q;
    assign key_reject  = key_reject_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed steps then random traffic against a queue-based model.
module tb_snake_dir_ctrl;

    localparam logic [1:0] INIT = 2'd3;
    localparam logic [3:0] K_UP    = 4'b1110;
    localparam logic [3:0] K_DOWN  = 4'b1101;
    localparam logic [3:0] K_LEFT  = 4'b1011;
    localparam logic [3:0] K_RIGHT = 4'b0111;
    localparam logic [3:0] K_NONE  = 4'b1111;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       key_flag;
    logic [3:0] key_value;
    logic       move_tick;
    logic       game_restart;
    logic [1:0] cur_dir;
    logic       dir_changed;
    logic [1:0] q_count;
    logic       key_reject;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_cur;
    int m_q[$];
    int m_dc;
    int m_kr;

    snake_dir_ctrl #(.INIT_DIR(INIT)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_flag     (key_flag),
        .key_value    (key_value),
        .move_tick    (move_tick),
        .game_restart (game_restart),
        .cur_dir      (cur_dir),
        .dir_changed  (dir_changed),
        .q_count      (q_count),
        .key_reject   (key_reject)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur = int'(INIT);
        m_dc  = 0;
        m_kr  = 0;
    endtask

    // One clock of the reference behaviour, written from the rules directly.
    task automatic model_step(input logic kf, input logic [3:0] kv, input logic tk, input logic rs);
        int zeros, nd, refd, legal;
        m_dc = 0;
        m_kr = 0;
        if (rs) begin
            m_q.delete();
            m_cur = int'(INIT);
            return;
        end
        zeros = 0;
        nd    = 0;
        for (int i = 0; i < 4; i++) if (!kv[i]) begin zeros++; nd = i; end
`ifdef SNAKE_DIR_QUEUE_EN
        refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_cur;
`else
        refd = m_cur;
`endif
        legal = 0;
        if (kf && zeros == 1 && nd != refd) begin
            if ((nd ^ refd) == 1) m_kr = 1;
            else                  legal = 1;
        end
        if (tk && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_dc  = 1;
        end
        if (legal) begin
`ifdef SNAKE_DIR_QUEUE_EN
            if (m_q.size() == 2) m_kr = 1;
            else                 m_q.push_back(nd);
`else
            m_q.delete();
            m_q.push_back(nd);
`endif
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cur_dir"},     int'(cur_dir),     m_cur);
        chk({tag, ".q_count"},     int'(q_count),     m_q.size());
        chk({tag, ".dir_changed"}, int'(dir_changed), m_dc);
        chk({tag, ".key_reject"},  int'(key_reject),  m_kr);
    endtask

    // Drive one cycle of inputs (from a negedge), then check one step after the edge.
    task automatic cycle(input logic kf, input logic [3:0] kv, input logic tk, input logic rs,
                         input string tag);
        key_flag     = kf;
        key_value    = kv;
        move_tick    = tk;
        game_restart = rs;
        model_step(kf, kv, tk, rs);
        @(posedge sys_clk);
        #1;
        chk_all(tag);
        @(negedge sys_clk);
        key_flag     = 1'b0;
        key_value    = K_NONE;
        move_tick    = 1'b0;
        game_restart = 1'b0;
    endtask

    initial begin
        logic       kf, tk, rs;
        logic [3:0] kv;
        sys_rst_n    = 1'b0;
        key_flag     = 1'b0;
        key_value    = K_NONE;
        move_tick    = 1'b0;
        game_restart = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Idle tick: heading holds
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "idle_tick");
        chk("idle_tick.const_dir", int'(cur_dir), 3);

        // Up then tick
        cycle(1'b1, K_UP, 1'b0, 1'b0, "press_up");
        chk("press_up.const_cnt", int'(q_count), 1);
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "tick_up");
        chk("tick_up.const_dir", int'(cur_dir), 0);
        chk("tick_up.const_dc", int'(dir_changed), 1);
        cycle(1'b0, K_NONE, 1'b0, 1'b0, "after_up");
        chk("after_up.const_dc", int'(dir_changed), 0);

        // Back to right, then reversal and two-key presses
        cycle(1'b1, K_RIGHT, 1'b0, 1'b0, "press_right");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "tick_right");
        cycle(1'b1, K_LEFT, 1'b0, 1'b0, "reverse_left");
        chk("reverse_left.const_kr", int'(key_reject), 1);
        cycle(1'b1, 4'b1100, 1'b0, 1'b0, "two_keys");
        chk("two_keys.const_kr", int'(key_reject), 0);
        cycle(1'b1, K_RIGHT, 1'b0, 1'b0, "same_dir");

        // Two quick presses then two ticks
        cycle(1'b1, K_UP, 1'b0, 1'b0, "q_up");
        cycle(1'b1, K_LEFT, 1'b0, 1'b0, "q_left");
        cycle(1'b1, K_DOWN, 1'b0, 1'b0, "q_down");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "q_tick1");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "q_tick2");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "q_tick3");

        // Key coincident with tick, pending and full cases
        cycle(1'b1, K_UP, 1'b0, 1'b0, "co_up");
        cycle(1'b1, K_RIGHT, 1'b0, 1'b0, "co_right");
        cycle(1'b1, K_DOWN, 1'b1, 1'b0, "co_down_tick");
        cycle(1'b1, K_LEFT, 1'b1, 1'b0, "co_empty_tick");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "co_drain1");
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "co_drain2");

        // Restart has priority over a key and a tick
        cycle(1'b1, K_UP, 1'b0, 1'b0, "rs_fill1");
        cycle(1'b1, K_RIGHT, 1'b0, 1'b0, "rs_fill2");
        cycle(1'b1, K_DOWN, 1'b1, 1'b1, "restart");
        chk("restart.const_dir", int'(cur_dir), 3);
        chk("restart.const_cnt", int'(q_count), 0);

        // Asynchronous reset with a pending turn
        cycle(1'b1, K_UP, 1'b0, 1'b0, "ar_fill");
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cycle(1'b0, K_NONE, 1'b1, 1'b0, "ar_tick");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            kf = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 4))
                0: kv = K_UP;
                1: kv = K_DOWN;
                2: kv = K_LEFT;
                3: kv = K_RIGHT;
                default: kv = 4'($urandom);
            endcase
            tk = ($urandom_range(0, 9) < 3);
            rs = ($urandom_range(0, 49) == 0);
            cycle(kf, kv, tk, rs, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
